// File: rtl/booth_seq_arbiter.sv
// Sequential radix-2 Booth multiplier shared round-robin between two requesters.
// One Booth step per clock; the result is registered one cycle after the last step.
module booth_seq_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WIDTH-1:0]   req0_mplr,
   input  logic [WIDTH-1:0]   req0_mcand,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WIDTH-1:0]   req1_mplr,
   input  logic [WIDTH-1:0]   req1_mcand,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res_id,
   output logic [2*WIDTH-1:0] res_product,
   output logic               busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH:0]   a, m, sum;
   logic [WIDTH-1:0] q;
   logic             q_1;
   logic [CW-1:0]    count;
   logic             id;
   logic             rr_last;
   logic             grant;
   logic             accept;
   logic [WIDTH-1:0] sel_mplr, sel_mcand;

   // rr_last holds the most recently served requester; reset to 1 so req0 wins first.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~rr_last;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant;
   assign req1_ready = (state == IDLE) && !rst && req1_valid && grant;
   assign accept     = req0_ready || req1_ready;
   assign sel_mplr   = grant ? req1_mplr  : req0_mplr;
   assign sel_mcand  = grant ? req1_mcand : req0_mcand;
   assign busy       = (state != IDLE);

   always_comb begin
      sum = a;
      case ({q[0], q_1})
         2'b01:   sum = a + m;
         2'b10:   sum = a - m;
         default: sum = a;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (count == LAST_STEP) state_next = DONE;
         DONE:    if (res_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         a           <= '0;
         m           <= '0;
         q           <= '0;
         q_1         <= 1'b0;
         count       <= '0;
         id          <= 1'b0;
         rr_last     <= 1'b1;
         res_valid   <= 1'b0;
         res_id      <= 1'b0;
         res_product <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  m       <= {sel_mcand[WIDTH-1], sel_mcand};
                  q       <= sel_mplr;
                  q_1     <= 1'b0;
                  a       <= '0;
                  count   <= '0;
                  id      <= grant;
                  rr_last <= grant;
               end
            end
            RUN: begin
               if (count != LAST_STEP) begin
                  // Arithmetic right shift of {A,Q,q_1} after the add/sub.
                  a     <= {sum[WIDTH], sum[WIDTH:1]};
                  q     <= {sum[0], q[WIDTH-1:1]};
                  q_1   <= q[0];
                  count <= count + 1'b1;
               end else begin
                  res_product <= {a[WIDTH-1:0], q};
                  res_id      <= id;
                  res_valid   <= 1'b1;
               end
            end
            DONE: begin
               if (res_ready) res_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_arbiter.sv
// Self-checking bench for booth_seq_arbiter: directed vector table, multi-cycle
// corner sequences and random traffic against a signed-multiply scoreboard.
module tb_booth_seq_arbiter;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req0_valid = 1'b0, req1_valid = 1'b0;
   logic           req0_ready, req1_ready;
   logic [W-1:0]   req0_mplr = '0, req0_mcand = '0, req1_mplr = '0, req1_mcand = '0;
   logic           res_valid, res_ready = 1'b0, res_id, busy;
   logic [2*W-1:0] res_product;

   int total = 0;
   int bad = 0;
   int accepts = 0;
   int results = 0;
   logic last_id = 1'b1;
   logic [2*W:0] exp_q[$];
   logic [2*W:0] got_q[$];

   typedef struct {
      logic           sel;
      logic [W-1:0]   mplr;
      logic [W-1:0]   mcand;
      logic [2*W-1:0] prod;
   } vec_t;
   vec_t vecs[8];

   booth_seq_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_mplr(req0_mplr), .req0_mcand(req0_mcand),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_mplr(req1_mplr), .req1_mcand(req1_mcand),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_id(res_id), .res_product(res_product), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: reference product is plain signed integer multiplication.
   task automatic monitor();
      int p;
      logic [2*W:0] e;
      if (rst) begin
         exp_q.delete();
         last_id = 1'b1;
         return;
      end
      check("two_readys", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (busy) check("ready_while_busy", {31'd0, req0_ready | req1_ready}, 32'd0);
      if (req0_valid && req0_ready) begin
         p = int'($signed(req0_mplr)) * int'($signed(req0_mcand));
         exp_q.push_back({1'b0, p[2*W-1:0]});
         if (req1_valid) check("fair_grant", 32'd0, {31'd0, ~last_id});
         last_id = 1'b0;
         accepts++;
      end
      if (req1_valid && req1_ready) begin
         p = int'($signed(req1_mplr)) * int'($signed(req1_mcand));
         exp_q.push_back({1'b1, p[2*W-1:0]});
         if (req0_valid) check("fair_grant", 32'd1, {31'd0, ~last_id});
         last_id = 1'b1;
         accepts++;
      end
      if (res_valid && res_ready) begin
         check("result_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("result", {15'd0, res_id, res_product}, {15'd0, e});
         end
         got_q.push_back({res_id, res_product});
         results++;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      monitor();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      sample();
      advance();
      rst = 1'b0;
   endtask

   task automatic drive(input logic sel, input logic v, input logic [W-1:0] mp, input logic [W-1:0] mc);
      if (sel) begin
         req1_valid = v; req1_mplr = mp; req1_mcand = mc;
      end else begin
         req0_valid = v; req0_mplr = mp; req0_mcand = mc;
      end
   endtask

   task automatic wait_accept(input logic sel, output logic got);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         sample();
         if (sel ? req1_ready : req0_ready) got = 1'b1;
         advance();
      end
      check("accept_seen", {31'd0, got}, 32'd1);
   endtask

   task automatic run_one(input logic sel, input logic [W-1:0] mp, input logic [W-1:0] mc,
                          input logic [2*W-1:0] exp);
      logic got;
      int lat;
      res_ready = 1'b1;
      drive(sel, 1'b1, mp, mc);
      wait_accept(sel, got);
      drive(sel, 1'b0, mp, mc);
      got = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40 && !got; i++) begin
         sample();
         if (res_valid) begin
            got = 1'b1;
            lat = i - 1;
         end else begin
            advance();
         end
      end
      check("latency", lat, W + 1);
      check("vec_product", {16'd0, res_product}, {16'd0, exp});
      check("vec_id", {31'd0, res_id}, {31'd0, sel});
      advance();
      sample();
      check("post_valid", {30'd0, res_valid, busy}, 32'd0);
      advance();
   endtask

   initial begin
      logic got;
      logic seen;
      logic [2*W:0] held;
      int order[$];
      int cyc;

      vecs[0] = '{1'b0, 8'h03, 8'hFC, 16'hFFF4};
      vecs[1] = '{1'b0, 8'h80, 8'h80, 16'h4000};
      vecs[2] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
      vecs[3] = '{1'b0, 8'h00, 8'hFF, 16'h0000};
      vecs[4] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
      vecs[5] = '{1'b1, 8'h05, 8'h07, 16'h0023};
      vecs[6] = '{1'b0, 8'hFA, 8'hFA, 16'h0024};
      vecs[7] = '{1'b1, 8'h80, 8'h7F, 16'hC080};

      // Reset values, with both requesters pushing during reset.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #2;
      check("rst_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
      check("rst_outputs", {13'd0, res_valid, res_id, busy, res_product}, 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      apply_reset();
      check("rst_release", {29'd0, res_valid, busy, res_id}, 32'd0);

      for (int i = 0; i < 8; i++) run_one(vecs[i].sel, vecs[i].mplr, vecs[i].mcand, vecs[i].prod);

      // Both requesters from reset: req0 first, then req1.
      apply_reset();
      got_q.delete();
      res_ready = 1'b1;
      drive(1'b0, 1'b1, 8'd5, 8'd7);
      drive(1'b1, 1'b1, 8'hFA, 8'hFA);
      for (int i = 0; i < 80 && order.size() < 2; i++) begin
         sample();
         got = req0_valid && req0_ready;
         seen = req1_valid && req1_ready;
         if (got) order.push_back(0);
         if (seen) order.push_back(1);
         advance();
         if (got) req0_valid = 1'b0;
         if (seen) req1_valid = 1'b0;
      end
      for (int i = 0; i < 40 && (busy || exp_q.size() != 0); i++) begin
         sample();
         advance();
      end
      check("both_count", order.size(), 2);
      if (order.size() == 2) begin
         check("both_first", order[0], 0);
         check("both_second", order[1], 1);
      end
      check("both_results", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("both_res0", {15'd0, got_q[0]}, 32'h0_0023);
         check("both_res1", {15'd0, got_q[1]}, 32'h1_0024);
      end

      // Backpressure in DONE with req1 waiting.
      res_ready = 1'b0;
      drive(1'b0, 1'b1, 8'd100, 8'hFD);
      wait_accept(1'b0, got);
      req0_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         sample();
         if (res_valid) seen = 1'b1; else advance();
      end
      check("bp_valid", {31'd0, seen}, 32'd1);
      held = {res_id, res_product};
      check("bp_value", {15'd0, held}, 32'h0_FED4);
      drive(1'b1, 1'b1, 8'd1, 8'd1);
      for (int i = 0; i < 5; i++) begin
         advance();
         sample();
         check("bp_hold", {14'd0, res_valid, res_id, res_product}, {14'd0, 1'b1, held});
         check("bp_readys", {30'd0, req0_ready, req1_ready}, 32'd0);
      end
      advance();
      req1_valid = 1'b0;
      res_ready = 1'b1;
      sample();
      advance();
      sample();
      check("bp_release", {31'd0, res_valid}, 32'd0);
      advance();

      // Reset three cycles after an accept abandons the operation.
      drive(1'b0, 1'b1, 8'd7, 8'd9);
      wait_accept(1'b0, got);
      req0_valid = 1'b0;
      advance();
      advance();
      advance();
      rst = 1'b1;
      #1;
      check("midrst_outputs", {13'd0, res_valid, busy, res_id, res_product}, 32'd0);
      sample();
      advance();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sample();
         if (res_valid || busy) seen = 1'b1;
         advance();
      end
      check("midrst_silent", {31'd0, seen}, 32'd0);
      run_one(1'b0, 8'd9, 8'hF7, 16'hFFAF);

      // Random traffic.
      accepts = 0;
      results = 0;
      cyc = 0;
      while (accepts < 1000 && cyc < 40000) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_mplr  = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
         req0_mcand = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
         req1_mplr  = ($urandom_range(0, 7) == 0) ? 8'h7F : W'($urandom);
         req1_mcand = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
         res_ready  = ($urandom_range(0, 3) != 0);
         sample();
         advance();
         cyc++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 40 && (busy || exp_q.size() != 0); i++) begin
         sample();
         advance();
      end
      check("rand_accepts", {31'd0, accepts >= 1000}, 32'd1);
      check("rand_drain", exp_q.size(), 0);
      check("rand_one_each", results, accepts);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
